filter_router: RTL and testbench
================================

FILTER_ROUTER -- requirements
Module: filter_router

Interface
REQ-001 Parameter DATA_W, default 12, pixel width (RGB444).
REQ-002 Parameter NUM_CH, default 4, number of filter channels, range 2..16.
REQ-003 Parameter SEL_W, default $clog2(NUM_CH), select width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 sel_in  in  SEL_W  requested filter channel.
REQ-007 data_in, sop_in, eop_in, valid_in  in  DATA_W,1,1,1  upstream stream sink.
REQ-008 ready_out  out  1  backpressure to upstream.
REQ-009 ch_data, ch_sop, ch_eop  out  DATA_W,1,1  broadcast of sink beat to all channels.
REQ-010 ch_valid  out  NUM_CH  per-channel valid; at most one bit set.
REQ-011 ch_ready  in  NUM_CH  per-channel ready toward router.
REQ-012 ch_data_in  in  NUM_CH*DATA_W  channel results; channel k at bits [k*DATA_W +: DATA_W].
REQ-013 ch_sop_in, ch_eop_in, ch_valid_in  in  NUM_CH each  channel result flags.
REQ-014 ch_ready_out  out  NUM_CH  per-channel ready from router.
REQ-015 data_out, sop_out, eop_out, valid_out  out  DATA_W,1,1,1  registered source stream.
REQ-016 ready_in  in  1  downstream backpressure.
REQ-017 active_sel  out  SEL_W  currently routed channel.
REQ-018 state_out  out  2  FSM state (IDLE=00, STREAM=01, DRAIN=10).
REQ-019 drop_cnt  out  16  count of discarded pre-SOP beats, saturating.
REQ-020 frame_cnt  out  16  count of completed frames, wrapping.

Function
REQ-021 Sink beat accepted when valid_in && ready_out; channel beat accepted when ch_valid_in[k] && ch_ready_out[k].
REQ-022 ch_valid[active_sel] = valid_in in IDLE/STREAM only; all other ch_valid bits 0.
REQ-023 IDLE: ready_out = ch_ready[active_sel] when sop_in=1, else 1 (non-SOP beats consumed, not forwarded, drop_cnt+1 saturating at 0xFFFF).
REQ-024 IDLE: active_sel <= sel_in each cycle without accepted SOP if sel_in < NUM_CH; out-of-range sel_in ignored, active_sel held.
REQ-025 IDLE -> STREAM on accepted SOP beat without eop_in; IDLE -> DRAIN on accepted beat with sop_in && eop_in.
REQ-026 STREAM: ready_out = ch_ready[active_sel]; active_sel frozen; sel_in changes ignored.
REQ-027 STREAM -> DRAIN on accepted beat with eop_in; an accepted sop_in in STREAM restarts frame, no state change.
REQ-028 DRAIN: ready_out=0, ch_valid all 0; -> IDLE on egress beat with eop accepted from active channel; frame_cnt+1 on that transition.
REQ-029 ch_ready_out[active_sel] = !valid_out || ready_in in every state; other channels 0.
REQ-030 Output register: on channel accept, data_out/sop_out/eop_out <= channel values, valid_out <= 1; else if ready_in, valid_out <= 0; latency 1 cycle.
REQ-031 Output register holds all fields stable while valid_out && !ready_in.
REQ-032 Sink-to-channel path combinational, zero latency.
REQ-033 Channel egress EOP while in IDLE or STREAM forwarded normally; no state change.

Reset
REQ-034 reset low: state=IDLE, active_sel=0, valid_out=0, data_out=0, sop_out=0, eop_out=0, drop_cnt=0, frame_cnt=0, immediately and asynchronously.
REQ-035 reset mid-frame discards in-flight frame and output register contents; resumes in IDLE on first edge after deassertion.

Verification
REQ-036 sel_in=2, 4-beat frame SOP..EOP, channel 2 echoes 1 cycle later, ready_in=1 -> data_out matches beats 1 cycle after channel valid, frame_cnt=1, state IDLE.
REQ-037 sel_in 2->1 mid-frame -> ch_valid stays 0b0100 until channel-2 EOP drained; next frame routed to channel 1, active_sel=1.
REQ-038 3 valid non-SOP beats in IDLE -> ready_out=1, ch_valid=0, drop_cnt=3.
REQ-039 ready_in=0 for 5 cycles with valid_out=1 -> data_out stable, ch_ready_out[active]=0; release -> no beat lost or duplicated.
REQ-040 single beat sop=eop=1 -> IDLE->DRAIN->IDLE, frame_cnt+1; sel_in=5 with NUM_CH=4 -> active_sel unchanged.
REQ-041 reset asserted in STREAM -> state=00, valid_out=0, counters 0 same cycle.

Source files
------------

// File: rtl/filter_router.sv
// Stream router: steers each upstream frame to one selectable filter channel
// and returns that channel's results through a single registered output stage.
// The channel choice is latched in IDLE and frozen until the routed channel
// has delivered the frame's EOP, so a frame never splits across channels.
module filter_router #(
    parameter int DATA_W = 12,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SEL_W-1:0]           sel_in,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       sop_in,
    input  logic                       eop_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    output logic [DATA_W-1:0]          ch_data,
    output logic                       ch_sop,
    output logic                       ch_eop,
    output logic [NUM_CH-1:0]          ch_valid,
    input  logic [NUM_CH-1:0]          ch_ready,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data_in,
    input  logic [NUM_CH-1:0]          ch_sop_in,
    input  logic [NUM_CH-1:0]          ch_eop_in,
    input  logic [NUM_CH-1:0]          ch_valid_in,
    output logic [NUM_CH-1:0]          ch_ready_out,
    output logic [DATA_W-1:0]          data_out,
    output logic                       sop_out,
    output logic                       eop_out,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [SEL_W-1:0]           active_sel,
    output logic [1:0]                 state_out,
    output logic [15:0]                drop_cnt,
    output logic [15:0]                frame_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        STREAM = 2'b01,
        DRAIN  = 2'b10
    } state_t;

    state_t              state;
    logic [NUM_CH-1:0]   sel_oh;
    logic                ch_ready_act;
    logic                act_valid;
    logic                act_sop;
    logic                act_eop;
    logic [DATA_W-1:0]   act_data;
    logic                fwd;
    logic                out_free;
    logic                sink_acc;
    logic                ch_acc;
    logic                sel_ok;

    assign ch_data   = data_in;
    assign ch_sop    = sop_in;
    assign ch_eop    = eop_in;
    assign state_out = state;
    assign out_free  = !valid_out || ready_in;
    assign sel_ok    = 32'(sel_in) < 32'(NUM_CH);
    assign sink_acc  = valid_in && ready_out;
    assign ch_acc    = act_valid && out_free;

    // Decode the routed channel and mux its ready and result signals
    always_comb begin
        sel_oh       = '0;
        ch_ready_act = 1'b0;
        act_valid    = 1'b0;
        act_sop      = 1'b0;
        act_eop      = 1'b0;
        act_data     = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (SEL_W'(k) == active_sel) begin
                sel_oh[k]    = 1'b1;
                ch_ready_act = ch_ready[k];
                act_valid    = ch_valid_in[k];
                act_sop      = ch_sop_in[k];
                act_eop      = ch_eop_in[k];
                act_data     = ch_data_in[k*DATA_W +: DATA_W];
            end
        end
    end

    // Sink-side handshake: pre-SOP beats in IDLE are swallowed, DRAIN blocks
    always_comb begin
        fwd       = 1'b0;
        ready_out = 1'b0;
        case (state)
            IDLE: begin
                fwd       = valid_in && sop_in;
                ready_out = sop_in ? ch_ready_act : 1'b1;
            end
            STREAM: begin
                fwd       = valid_in;
                ready_out = ch_ready_act;
            end
            default: begin
                fwd       = 1'b0;
                ready_out = 1'b0;
            end
        endcase
        ch_valid     = fwd ? sel_oh : '0;
        ch_ready_out = out_free ? sel_oh : '0;
    end

    // Frame FSM with channel selection and drop/frame counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            active_sel <= '0;
            drop_cnt   <= '0;
            frame_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sink_acc && sop_in) begin
                        state <= eop_in ? DRAIN : STREAM;
                    end else begin
                        if (valid_in && !sop_in && drop_cnt != '1)
                            drop_cnt <= drop_cnt + 16'd1;
                        if (sel_ok)
                            active_sel <= sel_in;
                    end
                end
                STREAM: begin
                    if (sink_acc && eop_in)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (ch_acc && act_eop) begin
                        state     <= IDLE;
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: load on channel accept, hold while stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
        end else if (ch_acc) begin
            valid_out <= 1'b1;
            data_out  <= act_data;
            sop_out   <= act_sop;
            eop_out   <= act_eop;
        end else if (ready_in) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_filter_router.sv
// Bench for filter_router: four echoing channel models (each applies its own
// data scramble) and a frame-level reference of the router rules plus an
// in-order scoreboard of every beat that should come out.
module tb_filter_router;

    localparam int DW = 12;
    localparam int NC = 4;
    localparam int SW = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [SW-1:0]      sel_in;
    logic [DW-1:0]      data_in;
    logic               sop_in, eop_in, valid_in;
    logic               ready_out;
    logic [DW-1:0]      ch_data;
    logic               ch_sop, ch_eop;
    logic [NC-1:0]      ch_valid, ch_ready;
    logic [NC*DW-1:0]   ch_data_in;
    logic [NC-1:0]      ch_sop_in, ch_eop_in, ch_valid_in, ch_ready_out;
    logic [DW-1:0]      data_out;
    logic               sop_out, eop_out, valid_out;
    logic               ready_in;
    logic [SW-1:0]      active_sel;
    logic [1:0]         state_out;
    logic [15:0]        drop_cnt, frame_cnt;

    // channel models
    logic [NC-1:0]      c_v, c_s, c_e, c_rdy;
    logic [DW-1:0]      c_d [NC];

    // reference model
    int                 m_st;      // 0 idle, 1 in frame, 2 waiting for result EOP
    int                 m_sel;
    int                 m_drop, m_frame;
    logic               m_vout, m_sop, m_eop;
    logic [DW-1:0]      m_d;
    logic [DW+1:0]      sb [$];

    int                 n_chk = 0;
    int                 n_pass = 0;

    always #5 clk = ~clk;

    filter_router #(.DATA_W(DW), .NUM_CH(NC), .SEL_W(SW)) dut (
        .clk(clk), .reset(reset), .sel_in(sel_in), .data_in(data_in),
        .sop_in(sop_in), .eop_in(eop_in), .valid_in(valid_in), .ready_out(ready_out),
        .ch_data(ch_data), .ch_sop(ch_sop), .ch_eop(ch_eop), .ch_valid(ch_valid),
        .ch_ready(ch_ready), .ch_data_in(ch_data_in), .ch_sop_in(ch_sop_in),
        .ch_eop_in(ch_eop_in), .ch_valid_in(ch_valid_in), .ch_ready_out(ch_ready_out),
        .data_out(data_out), .sop_out(sop_out), .eop_out(eop_out), .valid_out(valid_out),
        .ready_in(ready_in), .active_sel(active_sel), .state_out(state_out),
        .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
    );

    assign ch_valid_in = c_v;
    assign ch_sop_in   = c_s;
    assign ch_eop_in   = c_e;
    assign ch_ready    = c_rdy & (~c_v | ch_ready_out);

    always_comb begin
        ch_data_in = '0;
        for (int k = 0; k < NC; k++)
            ch_data_in[k*DW +: DW] = c_d[k];
    end

    function automatic logic [DW-1:0] xf(input int k, input logic [DW-1:0] d);
        logic [31:0] t;
        t = {20'd0, d} ^ (32'h0F0 + 32'(k) * 32'h111);
        return t[DW-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic s, input logic e,
                         input logic [DW-1:0] d, input logic [SW-1:0] sel, input logic rin);
        valid_in = v; sop_in = s; eop_in = e; data_in = d; sel_in = sel; ready_in = rin;
    endtask

    task automatic model_reset();
        m_st = 0; m_sel = 0; m_drop = 0; m_frame = 0;
        m_vout = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_d = '0;
        sb.delete();
        c_v = '0; c_s = '0; c_e = '0;
        for (int k = 0; k < NC; k++) c_d[k] = '0;
    endtask

    // One clock: check combinational outputs before the edge, advance the
    // reference and channel models across it, then check registered outputs.
    task automatic tick(output logic acc);
        logic          exp_rdy, sink_acc, ch_acc, out_pop;
        logic [NC-1:0] exp_chv, exp_cro, ing, egr;
        logic [DW-1:0] cd;
        logic          cs, ce;
        logic [DW+1:0] beat, got;
        int            r, nst;
        @(negedge clk);
        r = m_sel;
        exp_cro = '0;
        exp_cro[r] = !m_vout || ready_in;
        exp_chv = '0;
        case (m_st)
            0: begin exp_rdy = sop_in ? ch_ready[r] : 1'b1; exp_chv[r] = valid_in && sop_in; end
            1: begin exp_rdy = ch_ready[r]; exp_chv[r] = valid_in; end
            default: exp_rdy = 1'b0;
        endcase
        chk("ready_out", 32'(ready_out), 32'(exp_rdy));
        chk("ch_valid", 32'(ch_valid), 32'(exp_chv));
        chk("ch_ready_out", 32'(ch_ready_out), 32'(exp_cro));
        chk("ch_bcast", {18'd0, ch_sop, ch_eop, ch_data}, {18'd0, sop_in, eop_in, data_in});
        sink_acc = valid_in && exp_rdy;
        ch_acc   = c_v[r] && exp_cro[r];
        cd = c_d[r]; cs = c_s[r]; ce = c_e[r];
        out_pop = m_vout && ready_in;
        got = {sop_out, eop_out, data_out};
        ing = exp_chv & ch_ready;
        egr = c_v & exp_cro;
        acc = sink_acc;
        @(posedge clk);
        #1;
        if (out_pop) begin
            if (sb.size() == 0) chk("sb_underflow", 32'(got), 32'hFFFF_FFFF);
            else begin beat = sb.pop_front(); chk("egress_beat", 32'(got), 32'(beat)); end
        end
        for (int k = 0; k < NC; k++) begin
            if (egr[k]) c_v[k] = 1'b0;
            if (ing[k]) begin
                c_v[k] = 1'b1; c_s[k] = sop_in; c_e[k] = eop_in; c_d[k] = xf(k, data_in);
            end
        end
        nst = m_st;
        case (m_st)
            0: begin
                if (sink_acc && sop_in) begin
                    sb.push_back({sop_in, eop_in, xf(r, data_in)});
                    nst = eop_in ? 2 : 1;
                end else begin
                    if (valid_in && !sop_in && m_drop < 65535) m_drop++;
                    if (int'(sel_in) < NC) m_sel = int'(sel_in);
                end
            end
            1: if (sink_acc) begin
                sb.push_back({sop_in, eop_in, xf(r, data_in)});
                if (eop_in) nst = 2;
            end
            default: if (ch_acc && ce) begin nst = 0; m_frame = (m_frame + 1) % 65536; end
        endcase
        m_st = nst;
        if (ch_acc) begin m_vout = 1'b1; m_d = cd; m_sop = cs; m_eop = ce; end
        else if (ready_in) m_vout = 1'b0;
        chk("state_out", 32'(state_out), 32'(m_st));
        chk("active_sel", 32'(active_sel), 32'(m_sel));
        chk("valid_out", 32'(valid_out), 32'(m_vout));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frame));
        if (m_vout) chk("out_reg", {18'd0, sop_out, eop_out, data_out}, {18'd0, m_sop, m_eop, m_d});
    endtask

    // Present one sink beat until it is taken (bounded)
    task automatic send(input logic s, input logic e, input logic [SW-1:0] sel, input logic rin);
        logic          acc;
        logic [DW-1:0] d;
        int            n;
        d = DW'($urandom);
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            drive(1'b1, s, e, d, sel, rin);
            tick(acc);
            n++;
        end
        if (!acc) chk("send_timeout", 32'(n), 32'(0));
    endtask

    task automatic idle(input logic [SW-1:0] sel, input logic rin);
        logic acc;
        drive(1'b0, 1'b0, 1'b0, '0, sel, rin);
        tick(acc);
    endtask

    task automatic wait_idle(input logic [SW-1:0] sel);
        int n;
        n = 0;
        while ((m_st != 0 || m_vout) && n < 40) begin
            idle(sel, 1'b1);
            n++;
        end
        chk("drain_done", 32'(state_out), 32'(0));
    endtask

    initial begin
        int f0;
        logic acc;
        reset = 1'b0;
        c_rdy = '1;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_out), 32'(0));
        chk("rst_vout", 32'(valid_out), 32'(0));
        chk("rst_dout", 32'(data_out), 32'(0));
        chk("rst_counts", {drop_cnt, frame_cnt}, 32'(0));
        reset = 1'b1;

        // single frame through channel 2
        idle(3'd2, 1'b1);
        send(1'b1, 1'b0, 3'd2, 1'b1);
        send(1'b0, 1'b0, 3'd2, 1'b1);
        send(1'b0, 1'b0, 3'd2, 1'b1);
        send(1'b0, 1'b1, 3'd2, 1'b1);
        wait_idle(3'd2);
        chk("frame1_cnt", 32'(frame_cnt), 32'(1));
        chk("frame1_sel", 32'(active_sel), 32'(2));

        // non-SOP beats in IDLE are dropped
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, DW'($urandom), 3'd2, 1'b1);
            tick(acc);
            chk("drop_acc", 32'(acc), 32'(1));
        end
        chk("drop3", 32'(drop_cnt), 32'(3));

        // selection change mid-frame waits for the frame to finish
        idle(3'd2, 1'b1);
        send(1'b1, 1'b0, 3'd2, 1'b1);
        send(1'b0, 1'b0, 3'd1, 1'b1);
        chk("sel_frozen", 32'(active_sel), 32'(2));
        send(1'b0, 1'b0, 3'd1, 1'b1);
        send(1'b0, 1'b1, 3'd1, 1'b1);
        wait_idle(3'd1);
        idle(3'd1, 1'b1);
        chk("sel_switch", 32'(active_sel), 32'(1));
        send(1'b1, 1'b0, 3'd1, 1'b1);
        send(1'b0, 1'b0, 3'd1, 1'b1);
        send(1'b0, 1'b1, 3'd1, 1'b1);
        wait_idle(3'd1);
        chk("frame3_cnt", 32'(frame_cnt), 32'(3));

        // downstream stall for 5 cycles with a beat held
        send(1'b1, 1'b0, 3'd1, 1'b1);
        for (int i = 0; i < 5; i++) idle(3'd1, 1'b0);
        chk("stall_vout", 32'(valid_out), 32'(1));
        chk("stall_cro", 32'(ch_ready_out), 32'(0));
        send(1'b0, 1'b0, 3'd1, 1'b1);
        send(1'b0, 1'b1, 3'd1, 1'b1);
        wait_idle(3'd1);

        // out-of-range select ignored; single-beat frame
        idle(3'd5, 1'b1);
        chk("sel_oor", 32'(active_sel), 32'(1));
        f0 = m_frame;
        send(1'b1, 1'b1, 3'd5, 1'b1);
        chk("single_drain", 32'(state_out), 32'(2));
        wait_idle(3'd5);
        chk("single_frame", 32'(frame_cnt), 32'(f0 + 1));

        // randomized traffic with random backpressure on both sides
        for (int i = 0; i < 600; i++) begin
            c_rdy = NC'($urandom) | NC'($urandom);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0, DW'($urandom),
                  SW'($urandom_range(0, 5)), $urandom_range(0, 3) != 0);
            tick(acc);
        end
        c_rdy = '1;
        for (int i = 0; i < 20 && m_st == 1; i++) send(1'b0, 1'b1, 3'd0, 1'b1);
        wait_idle(3'd0);

        // asynchronous reset in the middle of a frame
        idle(3'd3, 1'b1);
        send(1'b1, 1'b0, 3'd3, 1'b1);
        send(1'b0, 1'b0, 3'd3, 1'b1);
        send(1'b0, 1'b0, 3'd3, 1'b1);
        chk("pre_rst_state", 32'(state_out), 32'(1));
        #2 reset = 1'b0;
        #1;
        chk("arst_state", 32'(state_out), 32'(0));
        chk("arst_vout", 32'(valid_out), 32'(0));
        chk("arst_out", {18'd0, sop_out, eop_out, data_out}, 32'(0));
        chk("arst_counts", {drop_cnt, frame_cnt}, 32'(0));
        chk("arst_sel", 32'(active_sel), 32'(0));
        model_reset();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        idle(3'd0, 1'b1);
        send(1'b1, 1'b1, 3'd0, 1'b1);
        wait_idle(3'd0);
        chk("post_rst_frame", 32'(frame_cnt), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
